crossbar_2x2_arbiter: RTL and testbench
=======================================

# crossbar_2x2_arbiter

Sequencing controller for the 2x2 4-bit crossbar datapath. It accepts packets from two source ports, each a stream of 4-bit beats with a destination bit and a `last` flag. It arbitrates round-robin when both sources target the same output, holds the crossbar configuration for the duration of multi-beat packets, and drives the registered crossbar outputs to the two sinks (LED banks / downstream logic).

## Interface
- `W`, default 4: beat data width.
- `clk` input, 1: sole clock; all state updates on rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `src0_valid`, `src1_valid` input, 1: source i offers a beat.
- `src0_dest`, `src1_dest` input, 1: target output (0 = dst0, 1 = dst1); must be stable for a whole packet.
- `src0_data`, `src1_data` input, W: beat payload.
- `src0_last`, `src1_last` input, 1: beat is the final beat of its packet.
- `src0_ready`, `src1_ready` output, 1: beat accepted this cycle (combinational from state and inputs).
- `dst0_valid`, `dst1_valid` output, 1: registered output beat valid.
- `dst0_data`, `dst1_data` output, W: registered output payload.
- `control` output, 1: registered crossbar select (0 = straight src0→dst0, src1→dst1; 1 = cross src0→dst1, src1→dst0).
- `rr_ptr` output, 1: current round-robin priority (0 = src0 favoured), for debug and verification.

## Operation
- Handshake: a beat transfers when `srcN_valid && srcN_ready`. Sinks always accept; there is no output backpressure.
- Required config per source: `cfg_i = dest_i XOR i`.
- FSM `mode`: IDLE, LOCKED. `burst0` and `burst1` flags mark a source mid-packet (a granted beat with last=0 has transferred, and the last beat has not).
- IDLE, only one source valid: grant it; config = its cfg.
- IDLE, both valid with different dests: grant both; config = `src0_dest`.
- IDLE, both valid with the same dest: the winner is the source indicated by `rr_ptr`. Config = winner's cfg. The loser gets ready=0.
- LOCKED: config is frozen at `control`. Source i is granted iff `valid_i` and `cfg_i == control`. A new packet from the other source may start under the frozen config.
- Transition IDLE→LOCKED when any granted beat has last=0. LOCKED→IDLE when, at the clock edge, both burst flags would be 0.
- A burst holder dropping valid mid-packet keeps the lock; no beat is emitted and the mode does not change.
- `rr_ptr` flips to the non-winner only when a contested (same-dest) winner's last beat transfers. Uncontested grants do not move it.
- A granted source with mismatched dest under LOCKED config waits; it is never dropped.

## Timing
- Latency: one cycle. A beat accepted in cycle t appears on `dstX_valid/data` in cycle t+1, together with the `control` value used for it.
- A `dstX_valid` with no grant deasserts in the next cycle; data holds its last value.
- `srcN_ready` is valid in the same cycle as `srcN_valid`. There is no ready-before-valid requirement.
- Back-to-back beats sustain 1 beat/cycle/source.
- Reset: `mode`=IDLE, `burst0`=`burst1`=0, `rr_ptr`=0, `control`=0, `dst*_valid`=0, `dst*_data`=0.
- `src*_ready`=0 while `rst`=1.
- Reset mid-packet aborts the packet. No beat from a reset cycle appears at the outputs.
- Single-beat packets (last=1 on the first beat) never enter LOCKED.

## Structure
- Shared package holds: `W` default, the encodings `XBAR_STRAIGHT`=0 and `XBAR_CROSS`=1, the mode encodings, and the `dest` constants.
- One sub-module, `xbar_2x2`: a purely combinational W-bit 2x2 crossbar (two data inputs, `control`, two data outputs).
- `xbar_2x2` is instantiated on the registered source beats. The valid bits are routed by the same select.
- The arbiter FSM, burst flags, `rr_ptr`, and output registers live in the top module.

## Test plan
- After reset, src0 sends 1 beat, dest=1, data=0xA → `src0_ready`=1 the same cycle; next cycle `dst1_valid`=1, `dst1_data`=0xA, `control`=1; `rr_ptr` stays 0.
- Both sources valid, src0 dest=0 data=0x3, src1 dest=1 data=0xC → both ready; next cycle dst0=0x3, dst1=0xC, `control`=0.
- Both sources target dest=0 with 1-beat packets 0x1 / 0x2 → src0 wins first (dst0=0x1), `rr_ptr`→1; src1 is granted the next cycle (dst0=0x2, `control`=1); `rr_ptr`→0.
- src1 sends a 3-beat packet 5,6,7 to dst1, with a 1-cycle valid gap after beat 2; src0 requests dst1 meanwhile → src0 held at ready=0 until beat 7 transfers; then src0 is granted and `control` switches to 1.
- During a src0 3-beat straight burst, src1 offers a dest=1 packet → src1 is granted concurrently under the frozen `control`=0.
- Assert `rst` after beat 1 of a 3-beat burst → next cycle all outputs 0, mode IDLE; a fresh packet is accepted normally.

Source files
------------

// File: rtl/crossbar_2x2_arbiter_pkg.sv
// Shared constants and types for the 2x2 crossbar arbiter and its datapath.
package crossbar_2x2_arbiter_pkg;

  localparam int W_DEFAULT = 4;

  localparam logic XBAR_STRAIGHT = 1'b0;
  localparam logic XBAR_CROSS    = 1'b1;

  localparam logic DEST_0 = 1'b0;
  localparam logic DEST_1 = 1'b1;

  typedef enum logic {
    MODE_IDLE   = 1'b0,
    MODE_LOCKED = 1'b1
  } mode_t;

endpackage

// File: rtl/crossbar_2x2_arbiter_xbar_2x2.sv
// Purely combinational W-bit 2x2 crossbar: straight passes in0->out0, cross swaps.
module xbar_2x2
  import crossbar_2x2_arbiter_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         control,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1
);

  assign out0 = (control == XBAR_CROSS) ? in1 : in0;
  assign out1 = (control == XBAR_CROSS) ? in0 : in1;

endmodule

// File: rtl/crossbar_2x2_arbiter.sv
// Round-robin arbiter and sequencer for a 2x2 crossbar carrying multi-beat packets.
// Handshake: a source beat transfers when srcN_valid && srcN_ready; sinks always accept.
module crossbar_2x2_arbiter
  import crossbar_2x2_arbiter_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src0_valid,
  input  logic         src0_dest,
  input  logic [W-1:0] src0_data,
  input  logic         src0_last,
  output logic         src0_ready,
  input  logic         src1_valid,
  input  logic         src1_dest,
  input  logic [W-1:0] src1_data,
  input  logic         src1_last,
  output logic         src1_ready,
  output logic         dst0_valid,
  output logic [W-1:0] dst0_data,
  output logic         dst1_valid,
  output logic [W-1:0] dst1_data,
  output logic         control,
  output logic         rr_ptr
);

  mode_t        mode;
  logic         burst0, burst1;
  logic         contested_q, winner_q;
  logic [W-1:0] beat0_q, beat1_q;
  logic         vld0_q, vld1_q;

  logic cfg0, cfg1;
  logic grant0, grant1, cfg, contested, winner, winner_last;
  logic burst0_n, burst1_n, ctrl_n;

  assign cfg0 = src0_dest ^ 1'b0;
  assign cfg1 = src1_dest ^ 1'b1;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    cfg       = control;
    contested = 1'b0;
    winner    = 1'b0;
    if (mode == MODE_LOCKED) begin
      grant0 = src0_valid && (cfg0 == control);
      grant1 = src1_valid && (cfg1 == control);
    end else if (src0_valid && src1_valid) begin
      if (src0_dest != src1_dest) begin
        grant0 = 1'b1;
        grant1 = 1'b1;
        cfg    = src0_dest;
      end else begin
        contested = 1'b1;
        winner    = rr_ptr;
        grant0    = !rr_ptr;
        grant1    = rr_ptr;
        cfg       = rr_ptr ? cfg1 : cfg0;
      end
    end else if (src0_valid) begin
      grant0 = 1'b1;
      cfg    = cfg0;
    end else if (src1_valid) begin
      grant1 = 1'b1;
      cfg    = cfg1;
    end
  end

  assign src0_ready = grant0 && !rst;
  assign src1_ready = grant1 && !rst;

  assign burst0_n    = grant0 ? !src0_last : burst0;
  assign burst1_n    = grant1 ? !src1_last : burst1;
  assign ctrl_n      = (grant0 || grant1) ? cfg : control;
  assign winner_last = winner_q ? (grant1 && src1_last) : (grant0 && src0_last);

  // An idle source's register is reloaded with whatever its new output already
  // shows, so a select change never disturbs the data held on that output.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= MODE_IDLE;
      burst0      <= 1'b0;
      burst1      <= 1'b0;
      contested_q <= 1'b0;
      winner_q    <= 1'b0;
      rr_ptr      <= 1'b0;
      control     <= XBAR_STRAIGHT;
      vld0_q      <= 1'b0;
      vld1_q      <= 1'b0;
      beat0_q     <= '0;
      beat1_q     <= '0;
    end else begin
      mode    <= (burst0_n || burst1_n) ? MODE_LOCKED : MODE_IDLE;
      burst0  <= burst0_n;
      burst1  <= burst1_n;
      control <= ctrl_n;
      vld0_q  <= grant0;
      vld1_q  <= grant1;
      beat0_q <= grant0 ? src0_data : (ctrl_n ? dst1_data : dst0_data);
      beat1_q <= grant1 ? src1_data : (ctrl_n ? dst0_data : dst1_data);
      if (mode == MODE_IDLE) begin
        if (contested) begin
          if (winner ? src1_last : src0_last) begin
            rr_ptr      <= !winner;
            contested_q <= 1'b0;
          end else begin
            contested_q <= 1'b1;
            winner_q    <= winner;
          end
        end else begin
          contested_q <= 1'b0;
        end
      end else if (contested_q && winner_last) begin
        rr_ptr      <= !winner_q;
        contested_q <= 1'b0;
      end
    end
  end

  xbar_2x2 #(.W(W)) u_xbar_data (
    .in0     (beat0_q),
    .in1     (beat1_q),
    .control (control),
    .out0    (dst0_data),
    .out1    (dst1_data)
  );

  xbar_2x2 #(.W(1)) u_xbar_valid (
    .in0     (vld0_q),
    .in1     (vld1_q),
    .control (control),
    .out0    (dst0_valid),
    .out1    (dst1_valid)
  );

endmodule

// File: tb/tb_crossbar_2x2_arbiter.sv
// Directed bench for crossbar_2x2_arbiter with hand-computed expectations.
module tb_crossbar_2x2_arbiter;
  import crossbar_2x2_arbiter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         src0_valid, src0_dest, src0_last, src0_ready;
  logic         src1_valid, src1_dest, src1_last, src1_ready;
  logic [W-1:0] src0_data, src1_data;
  logic         dst0_valid, dst1_valid, control, rr_ptr;
  logic [W-1:0] dst0_data, dst1_data;

  int errors = 0;
  int checks = 0;

  crossbar_2x2_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .src0_valid (src0_valid),
    .src0_dest  (src0_dest),
    .src0_data  (src0_data),
    .src0_last  (src0_last),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_dest  (src1_dest),
    .src1_data  (src1_data),
    .src1_last  (src1_last),
    .src1_ready (src1_ready),
    .dst0_valid (dst0_valid),
    .dst0_data  (dst0_data),
    .dst1_valid (dst1_valid),
    .dst1_data  (dst1_data),
    .control    (control),
    .rr_ptr     (rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic d, input logic [W-1:0] dat, input logic l);
    src0_valid = v; src0_dest = d; src0_data = dat; src0_last = l;
  endtask

  task automatic drv1(input logic v, input logic d, input logic [W-1:0] dat, input logic l);
    src1_valid = v; src1_dest = d; src1_data = dat; src1_last = l;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, 1'b0);
    drv1(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic c,
                         input logic rr);
    chk({tag, ".dst0_valid"}, dst0_valid, v0);
    chk({tag, ".dst0_data"},  dst0_data,  d0);
    chk({tag, ".dst1_valid"}, dst1_valid, v1);
    chk({tag, ".dst1_data"},  dst1_data,  d1);
    chk({tag, ".control"},    control,    c);
    chk({tag, ".rr_ptr"},     rr_ptr,     rr);
  endtask

  initial begin
    // reset: ready suppressed, everything cleared
    rst = 1'b1;
    idle();
    drv0(1'b1, 1'b1, 4'hF, 1'b1);
    #1;
    chk("rst.src0_ready", src0_ready, 1'b0);
    tick();
    tick();
    chk_out("rst", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("rst.mode", dut.mode, MODE_IDLE);
    rst = 1'b0;
    idle();
    tick();
    chk_out("post_rst", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // single beat src0 -> dst1
    drv0(1'b1, 1'b1, 4'hA, 1'b1);
    #1;
    chk("t1.src0_ready", src0_ready, 1'b1);
    chk("t1.src1_ready", src1_ready, 1'b0);
    tick();
    chk_out("t1", 1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0);
    idle();
    tick();
    chk_out("t1.hold", 1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 1'b0);

    // both sources, different dests
    drv0(1'b1, 1'b0, 4'h3, 1'b1);
    drv1(1'b1, 1'b1, 4'hC, 1'b1);
    #1;
    chk("t2.src0_ready", src0_ready, 1'b1);
    chk("t2.src1_ready", src1_ready, 1'b1);
    tick();
    chk_out("t2", 1'b1, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0);
    idle();
    tick();

    // contention on dst0: src0 wins, then src1, then src0 again
    drv0(1'b1, 1'b0, 4'h1, 1'b1);
    drv1(1'b1, 1'b0, 4'h2, 1'b1);
    #1;
    chk("t3a.src0_ready", src0_ready, 1'b1);
    chk("t3a.src1_ready", src1_ready, 1'b0);
    tick();
    chk_out("t3a", 1'b1, 4'h1, 1'b0, 4'hC, 1'b0, 1'b1);
    drv0(1'b1, 1'b0, 4'h4, 1'b1);
    #1;
    chk("t3b.src0_ready", src0_ready, 1'b0);
    chk("t3b.src1_ready", src1_ready, 1'b1);
    tick();
    chk_out("t3b", 1'b1, 4'h2, 1'b0, 4'hC, 1'b1, 1'b0);
    drv1(1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t3c.src0_ready", src0_ready, 1'b1);
    tick();
    chk_out("t3c", 1'b1, 4'h4, 1'b0, 4'hC, 1'b0, 1'b0);
    idle();
    tick();

    // src1 3-beat packet to dst1 with a gap; src0 waits for dst1
    drv1(1'b1, 1'b1, 4'h5, 1'b0);
    #1;
    chk("t4a.src1_ready", src1_ready, 1'b1);
    tick();
    chk_out("t4a", 1'b0, 4'h4, 1'b1, 4'h5, 1'b0, 1'b0);
    chk("t4a.mode", dut.mode, MODE_LOCKED);
    drv1(1'b1, 1'b1, 4'h6, 1'b0);
    drv0(1'b1, 1'b1, 4'h9, 1'b1);
    #1;
    chk("t4b.src1_ready", src1_ready, 1'b1);
    chk("t4b.src0_ready", src0_ready, 1'b0);
    tick();
    chk_out("t4b", 1'b0, 4'h4, 1'b1, 4'h6, 1'b0, 1'b0);
    drv1(1'b0, 1'b1, 4'h0, 1'b0);
    #1;
    chk("t4c.src0_ready", src0_ready, 1'b0);
    tick();
    chk_out("t4c", 1'b0, 4'h4, 1'b0, 4'h6, 1'b0, 1'b0);
    chk("t4c.mode", dut.mode, MODE_LOCKED);
    drv1(1'b1, 1'b1, 4'h7, 1'b1);
    #1;
    chk("t4d.src1_ready", src1_ready, 1'b1);
    chk("t4d.src0_ready", src0_ready, 1'b0);
    tick();
    chk_out("t4d", 1'b0, 4'h4, 1'b1, 4'h7, 1'b0, 1'b0);
    chk("t4d.mode", dut.mode, MODE_IDLE);
    drv1(1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    chk("t4e.src0_ready", src0_ready, 1'b1);
    tick();
    chk_out("t4e", 1'b0, 4'h4, 1'b1, 4'h9, 1'b1, 1'b0);
    idle();
    tick();

    // src0 straight burst; src1 joins under the frozen config
    drv0(1'b1, 1'b0, 4'hB, 1'b0);
    #1;
    chk("t5a.src0_ready", src0_ready, 1'b1);
    tick();
    chk_out("t5a", 1'b1, 4'hB, 1'b0, 4'h9, 1'b0, 1'b0);
    chk("t5a.mode", dut.mode, MODE_LOCKED);
    drv0(1'b1, 1'b0, 4'hD, 1'b0);
    drv1(1'b1, 1'b1, 4'h6, 1'b1);
    #1;
    chk("t5b.src0_ready", src0_ready, 1'b1);
    chk("t5b.src1_ready", src1_ready, 1'b1);
    tick();
    chk_out("t5b", 1'b1, 4'hD, 1'b1, 4'h6, 1'b0, 1'b0);
    drv0(1'b1, 1'b0, 4'hE, 1'b1);
    drv1(1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("t5c", 1'b1, 4'hE, 1'b0, 4'h6, 1'b0, 1'b0);
    chk("t5c.mode", dut.mode, MODE_IDLE);
    idle();
    tick();

    // reset in the middle of a burst
    drv0(1'b1, 1'b1, 4'h8, 1'b0);
    tick();
    chk_out("t6a", 1'b0, 4'hE, 1'b1, 4'h8, 1'b1, 1'b0);
    chk("t6a.mode", dut.mode, MODE_LOCKED);
    rst = 1'b1;
    drv0(1'b1, 1'b1, 4'h9, 1'b0);
    #1;
    chk("t6b.src0_ready", src0_ready, 1'b0);
    tick();
    chk_out("t6b", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("t6b.mode", dut.mode, MODE_IDLE);
    rst = 1'b0;
    drv0(1'b1, 1'b0, 4'h5, 1'b1);
    #1;
    chk("t6c.src0_ready", src0_ready, 1'b1);
    tick();
    chk_out("t6c", 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("t6c.mode", dut.mode, MODE_IDLE);
    idle();
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
